// File: rtl/act_lut_pkg.sv
// Shared constants and types for the activation-function LUT loader.
package act_lut_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ADDR_W      = 4;
  localparam int unsigned LUT_ENTRIES = 2**ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK
  } state_t;

  typedef logic signed [DATA_W-1:0] lut_entry_t;

endpackage

// File: rtl/act_lut_loader_if.sv
// Byte-stream valid/ready channel feeding the LUT loader.
interface act_lut_loader_if #(
  parameter int DATA_W = act_lut_pkg::DATA_W
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/act_lut_regfile.sv
// Shadow/active register pair for the LUT: shadow is filled byte by byte,
// active is replaced wholesale by a single commit strobe and is the only
// table visible on the dual read port (addr, addr+1).
module act_lut_regfile import act_lut_pkg::*; #(
  parameter int DATA_W = act_lut_pkg::DATA_W,
  parameter int ADDR_W = act_lut_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [ADDR_W:0]          i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_commit,
  input  logic [ADDR_W-1:0]        i_rd_addr,
  output logic signed [DATA_W-1:0] o_rd_base,
  output logic signed [DATA_W-1:0] o_rd_next
);

  localparam int unsigned ENTRIES = 2**ADDR_W + 1;

  logic [DATA_W-1:0] r_shadow [ENTRIES];
  logic [DATA_W-1:0] r_active [ENTRIES];
  logic [ADDR_W:0]   w_rd_lo;
  logic [ADDR_W:0]   w_rd_hi;

  // Shadow write port and whole-table commit into the active copy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (i_wr_en) begin
        r_shadow[i_wr_addr] <= i_wr_data;
      end
      if (i_commit) begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
          r_active[i] <= r_shadow[i];
        end
      end
    end
  end

  // Combinational read of two adjacent entries; top address reads the extra
  // 17th entry instead of wrapping.
  always_comb begin
    w_rd_lo   = (ADDR_W+1)'(i_rd_addr);
    w_rd_hi   = w_rd_lo + (ADDR_W+1)'(1);
    o_rd_base = r_active[w_rd_lo];
    o_rd_next = r_active[w_rd_hi];
  end

endmodule

// File: rtl/act_lut_loader.sv
// Writer side of the activation LUT: accepts 17 entries plus a checksum byte
// over a valid/ready stream, and commits the table only when the checksum
// matches. Exposes the active table on a combinational read port.
module act_lut_loader import act_lut_pkg::*; #(
  parameter int DATA_W = act_lut_pkg::DATA_W,
  parameter int ADDR_W = act_lut_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  act_lut_loader_if.slave          s_in,
  input  logic [ADDR_W-1:0]        address,
  output logic signed [DATA_W-1:0] base,
  output logic signed [DATA_W-1:0] next_data,
  output logic                     table_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned ENTRIES = 2**ADDR_W + 1;
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ENTRIES - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_sum;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_table_valid;

  logic w_hs;
  logic w_shadow_we;
  logic w_csum_ok;
  logic w_commit;

  // Handshake qualification; a load_start on a LOAD edge drops that byte,
  // but a CHECK-byte handshake still commits regardless of load_start.
  always_comb begin
    w_hs        = s_in.in_valid & r_in_ready;
    w_shadow_we = (r_state == LOAD) & w_hs & ~load_start;
    w_csum_ok   = (r_sum == s_in.in_data);
    w_commit    = (r_state == CHECK) & w_hs & w_csum_ok;
  end

  // Load sequencer: counter, checksum accumulator and registered status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_sum         <= '0;
      r_in_ready    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_table_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load_start) begin
            r_state    <= LOAD;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (load_start) begin
            r_cnt <= '0;
            r_sum <= '0;
          end else if (w_hs) begin
            r_sum <= r_sum + s_in.in_data;
            if (r_cnt == LAST_IDX) begin
              r_state <= CHECK;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        CHECK: begin
          if (w_hs) begin
            if (w_csum_ok) begin
              r_done        <= 1'b1;
              r_table_valid <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
          if (load_start) begin
            r_state <= LOAD;
            r_cnt   <= '0;
            r_sum   <= '0;
          end else if (w_hs) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  act_lut_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_shadow_we),
    .i_wr_addr (r_cnt),
    .i_wr_data (s_in.in_data),
    .i_commit  (w_commit),
    .i_rd_addr (address),
    .o_rd_base (base),
    .o_rd_next (next_data)
  );

  assign s_in.in_ready = r_in_ready;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign table_valid   = r_table_valid;

endmodule

// File: tb/tb_act_lut_loader.sv
// Directed bench for act_lut_loader: table-driven read checks plus
// hand-written load, restart, commit-timing and reset sequences.
module tb_act_lut_loader;
  import act_lut_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load_start = 1'b0;
  logic [3:0]       address = '0;
  lut_entry_t       base;
  lut_entry_t       next_data;
  logic             table_valid;
  logic             busy;
  logic             done;
  logic             err;

  act_lut_loader_if #(.DATA_W(8)) u_if ();

  act_lut_loader #(
    .DATA_W (8),
    .ADDR_W (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .s_in        (u_if.slave),
    .address     (address),
    .base        (base),
    .next_data   (next_data),
    .table_valid (table_valid),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    int         exp_base;
    int         exp_next;
  } rd_vec_t;

  rd_vec_t    rdv [6];
  logic [7:0] stream [17];
  int         n_vec = 0;
  int         n_err = 0;
  int         seen_done = 0;
  int         seen_err = 0;
  logic [7:0] cs;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", nm, $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (done === 1'b1) seen_done++;
    if (err === 1'b1) seen_err++;
  endtask

  function automatic logic [7:0] sum8();
    logic [7:0] s = '0;
    for (int k = 0; k < 17; k++) s = s + stream[k];
    return s;
  endfunction

  task automatic fill_ramp();
    for (int k = 0; k < 17; k++) stream[k] = 8'(k * 8 - 64);
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap_pct);
    int n;
    u_if.in_valid = 1'b0;
    n = 0;
    while ($urandom_range(0, 99) < gap_pct && n < 20) begin
      tick();
      n++;
    end
    u_if.in_valid = 1'b1;
    u_if.in_data  = d;
    n = 0;
    while (u_if.in_ready !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) begin
      n_vec++;
      n_err++;
      $display("FAIL in_ready_timeout: got in_ready=%b, expected 1 within 64 cycles", u_if.in_ready);
    end
    tick();
    u_if.in_valid = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    chk("ready_after_start", 32'(u_if.in_ready), 1);
  endtask

  task automatic send_entries(input int gap_pct);
    for (int k = 0; k < 17; k++) send_byte(stream[k], gap_pct);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    // Ramp k*8-64 for k=0..16 is symmetric about zero, so its byte sum is 0x00.
    rdv[0] = '{4'd0,  -64, -56};
    rdv[1] = '{4'd3,  -40, -32};
    rdv[2] = '{4'd7,   -8,   0};
    rdv[3] = '{4'd8,    0,   8};
    rdv[4] = '{4'd12,  32,  40};
    rdv[5] = '{4'd15,  56,  64};

    u_if.in_valid = 1'b0;
    u_if.in_data  = '0;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(u_if.in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_table_valid", 32'(table_valid), 0);
    chk("rst_base", 32'(base), 0);
    chk("rst_next", 32'(next_data), 0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Bad checksum: err pulse, nothing committed.
    fill_ramp();
    cs = sum8();
    chk("ramp_checksum", 32'(cs), 32'h00);
    start_load();
    send_entries(0);
    send_byte(cs + 8'd1, 0);
    chk("bad_done", 32'(done), 0);
    chk("bad_err", 32'(err), 1);
    chk("bad_table_valid", 32'(table_valid), 0);
    tick();
    chk("bad_err_clear", 32'(err), 0);
    chk("bad_busy_idle", 32'(busy), 0);
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      chk("bad_base_zero", 32'($signed(base)), 0);
      chk("bad_next_zero", 32'($signed(next_data)), 0);
    end

    // Bytes offered in IDLE are not absorbed.
    u_if.in_valid = 1'b1;
    u_if.in_data  = 8'hAA;
    #1;
    chk("idle_ready", 32'(u_if.in_ready), 0);
    repeat (3) tick();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ready_hold", 32'(u_if.in_ready), 0);
    u_if.in_valid = 1'b0;

    // Good load with random valid gaps.
    start_load();
    send_entries(30);
    send_byte(cs, 30);
    chk("good_done", 32'(done), 1);
    chk("good_err", 32'(err), 0);
    chk("good_table_valid", 32'(table_valid), 1);
    tick();
    chk("good_done_clear", 32'(done), 0);
    chk("good_busy_idle", 32'(busy), 0);
    for (int i = 0; i < 6; i++) begin
      address = rdv[i].addr;
      #1;
      chk("rd_base", 32'($signed(base)), 32'(rdv[i].exp_base));
      chk("rd_next", 32'($signed(next_data)), 32'(rdv[i].exp_next));
    end

    // Restart after 9 bytes, restart colliding with a handshake drops that byte.
    for (int k = 0; k < 17; k++) stream[k] = 8'h7F;
    cs = sum8();
    chk("flat_checksum", 32'(cs), 32'h6F);
    seen_done = 0;
    seen_err  = 0;
    start_load();
    for (int k = 0; k < 9; k++) send_byte(8'h11, 0);
    load_start    = 1'b1;
    u_if.in_valid = 1'b1;
    u_if.in_data  = 8'h55;
    tick();
    load_start    = 1'b0;
    u_if.in_valid = 1'b0;
    chk("restart_busy", 32'(busy), 1);
    send_entries(0);
    send_byte(cs, 0);
    chk("restart_done", 32'(done), 1);
    tick();
    chk("restart_done_count", 32'(seen_done), 1);
    chk("restart_err_count", 32'(seen_err), 0);
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      chk("flat_base", 32'($signed(base)), 127);
      chk("flat_next", 32'($signed(next_data)), 127);
    end

    // Read port switches exactly on the commit edge.
    address = 4'd15;
    fill_ramp();
    cs = sum8();
    start_load();
    send_entries(0);
    u_if.in_valid = 1'b1;
    u_if.in_data  = cs;
    #1;
    chk("commit_ready", 32'(u_if.in_ready), 1);
    chk("pre_commit_base", 32'($signed(base)), 127);
    chk("pre_commit_next", 32'($signed(next_data)), 127);
    tick();
    u_if.in_valid = 1'b0;
    chk("post_commit_base", 32'($signed(base)), 56);
    chk("post_commit_next", 32'($signed(next_data)), 64);
    chk("post_commit_done", 32'(done), 1);
    tick();

    // Asynchronous reset mid-load clears everything immediately.
    start_load();
    for (int k = 0; k < 12; k++) send_byte(stream[k], 0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_table_valid", 32'(table_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ready", 32'(u_if.in_ready), 0);
    chk("midrst_base", 32'($signed(base)), 0);
    chk("midrst_next", 32'($signed(next_data)), 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    address = 4'd3;
    start_load();
    send_entries(0);
    send_byte(cs, 0);
    chk("fresh_done", 32'(done), 1);
    chk("fresh_table_valid", 32'(table_valid), 1);
    #1;
    chk("fresh_base", 32'($signed(base)), -40);
    chk("fresh_next", 32'($signed(next_data)), -32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
